// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: buffers APU requests and steps each through ceil(vl/NUM_LANES) beats.
// Optional perf counters (perf_retired, perf_stall) are compiled in with VSEQ_PERF_COUNT_EN.
module vector_issue_sequencer #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned VL_WIDTH    = 5,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 apu_req,
  output logic                 apu_gnt,
  input  logic [2:0][31:0]     apu_operands,
  output logic                 apu_rvalid,
  input  logic [VL_WIDTH-1:0]  vl,
  output logic [4:0]           vs1_addr,
  output logic [4:0]           vs2_addr,
  output logic [4:0]           vd_addr,
  output logic [NUM_LANES-1:0] lane_en,
  output logic                 beat_last,
  output logic                 vec_reg_write,
  output logic                 csr_write,
  output logic [31:0]          scalar_operand,
  output logic [10:0]          immediate_operand,
  output logic                 vlsu_en_o,
  output logic                 vlsu_load_o,
  output logic                 vlsu_store_o,
  input  logic                 vlsu_ready_i,
  output logic                 busy
`ifdef VSEQ_PERF_COUNT_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_stall
`endif
);

  localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
  localparam int unsigned PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned VW1       = VL_WIDTH + 1;
  localparam int unsigned EW        = VL_WIDTH + LANE_BITS + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_MEM    = 2'd2;
  localparam logic [1:0] ST_RETIRE = 2'd3;

  localparam logic [6:0] OPC_OP_V     = 7'b1010111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [2:0] V_OPMVV      = 3'b010;
  localparam logic [2:0] V_OPCFG      = 3'b111;

  // Instruction FIFO
  logic [31:0]      instr_q [QUEUE_DEPTH];
  logic [31:0]      op1_q   [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_empty, fifo_full, push, pop;

  logic [1:0]          state_q, state_d;
  logic [VL_WIDTH-1:0] beat_q, beat_d;
  logic [VL_WIDTH-1:0] vl_q, vl_d;

  logic unused_op2;
  assign unused_op2 = ^apu_operands[2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign apu_gnt    = ~fifo_full;
  assign push       = apu_req & ~fifo_full;
  assign pop        = (state_q == ST_RETIRE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q[i] <= '0;
        op1_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= apu_operands[0];
        op1_q[wr_ptr_q]   <= apu_operands[1];
        wr_ptr_q <= (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-entry decode
  logic [31:0] head_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  funct6;
  logic [4:0]  vd_f, vs1_f, vs2_f;
  logic        is_opv, is_load, is_store, is_mem, is_cfg, is_arith, is_red;
  logic        known_op, fixed_addr, single_beat;

  assign head_instr = instr_q[rd_ptr_q];
  assign opcode     = head_instr[6:0];
  assign vd_f       = head_instr[11:7];
  assign funct3     = head_instr[14:12];
  assign vs1_f      = head_instr[19:15];
  assign vs2_f      = head_instr[24:20];
  assign funct6     = head_instr[31:26];

  assign is_opv      = (opcode == OPC_OP_V);
  assign is_load     = (opcode == OPC_LOAD_FP);
  assign is_store    = (opcode == OPC_STORE_FP);
  assign is_mem      = is_load | is_store;
  assign is_cfg      = is_opv & (funct3 == V_OPCFG);
  assign is_arith    = is_opv & ~is_cfg;
  assign is_red      = is_opv & (funct3 == V_OPMVV) &
                       ((funct6 == 6'b000000) | (funct6 == 6'b000111) | (funct6 == 6'b110001));
  assign known_op    = is_opv | is_mem;
  assign fixed_addr  = is_red | is_mem;
  assign single_beat = is_cfg | ~known_op;

  // Beat count = max(1, ceil(vl/NUM_LANES)); last index compared against beat counter
  logic [VW1-1:0] vl_round, n_beats, last_idx;
  logic           last_beat;

  assign vl_round  = {1'b0, vl_q} + VW1'(NUM_LANES - 1);
  assign n_beats   = vl_round >> LANE_BITS;
  assign last_idx  = (n_beats == '0) ? '0 : n_beats - 1'b1;
  assign last_beat = single_beat | ({1'b0, beat_q} == last_idx);

  logic [EW-1:0]        elem_base;
  logic [NUM_LANES-1:0] lanes_c;
  logic [NUM_LANES-1:0] lanes_act;

  assign elem_base = EW'({beat_q, {LANE_BITS{1'b0}}});

  always_comb begin
    lanes_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes_c[i] = (elem_base + EW'(i)) < EW'(vl_q);
    end
  end

  assign lanes_act = single_beat ? '0 : lanes_c;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vl_d    = vl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_EXEC;
          vl_d    = vl;
          beat_d  = '0;
        end
      end
      ST_EXEC: begin
        if (is_mem) begin
          state_d = ST_MEM;
        end else if (last_beat) begin
          state_d = ST_RETIRE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_MEM: begin
        if (vlsu_ready_i) begin
          if (last_beat) begin
            state_d = ST_RETIRE;
            beat_d  = '0;
          end else begin
            state_d = ST_EXEC;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      ST_RETIRE: begin
        // The entry being popped is the head; anything behind it (or arriving now) starts at once
        if ((count_q > CNT_W'(1)) || push) begin
          state_d = ST_EXEC;
          vl_d    = vl;
          beat_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vl_q    <= vl_d;
    end
  end

  logic       active;
  logic [4:0] beat_lo;

  assign active  = (state_q == ST_EXEC) | (state_q == ST_MEM);
  assign beat_lo = 5'(beat_q);

  always_comb begin
    vs1_addr      = '0;
    vs2_addr      = '0;
    vd_addr       = '0;
    lane_en       = '0;
    beat_last     = 1'b0;
    vlsu_en_o     = 1'b0;
    vlsu_load_o   = 1'b0;
    vlsu_store_o  = 1'b0;
    if (active) begin
      vs1_addr     = fixed_addr ? vs1_f : vs1_f + beat_lo;
      vs2_addr     = fixed_addr ? vs2_f : vs2_f + beat_lo;
      vd_addr      = fixed_addr ? vd_f : vd_f + beat_lo;
      lane_en      = lanes_act;
      beat_last    = last_beat;
      vlsu_en_o    = is_mem;
      vlsu_load_o  = is_load;
      vlsu_store_o = is_store;
    end
  end

  assign vec_reg_write = (lanes_act != '0) &
                         (((state_q == ST_EXEC) & is_arith) |
                          ((state_q == ST_MEM) & is_load & vlsu_ready_i));
  assign csr_write         = (state_q == ST_EXEC) & is_cfg;
  assign apu_rvalid        = (state_q == ST_RETIRE);
  assign busy              = ~fifo_empty | (state_q != ST_IDLE);
  assign scalar_operand    = op1_q[rd_ptr_q];
  assign immediate_operand = (funct3 == V_OPCFG) ? head_instr[30:20]
                                                 : {{6{head_instr[19]}}, head_instr[19:15]};

`ifdef VSEQ_PERF_COUNT_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state_q == ST_RETIRE) perf_retired <= perf_retired + 1'b1;
      if ((state_q == ST_MEM) && !vlsu_ready_i) perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  // Counters not built; ports are absent.
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (n_reset && (state_q == ST_EXEC) && !known_op) begin
      $error("vector_issue_sequencer: unknown major opcode %b", opcode);
    end
  end
`endif

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer (NUM_LANES=4, VL_WIDTH=5, QUEUE_DEPTH=2).
module tb_vector_issue_sequencer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        apu_req;
  logic        apu_gnt;
  logic [2:0][31:0] apu_operands;
  logic        apu_rvalid;
  logic [4:0]  vl;
  logic [4:0]  vs1_addr, vs2_addr, vd_addr;
  logic [3:0]  lane_en;
  logic        beat_last, vec_reg_write, csr_write;
  logic [31:0] scalar_operand;
  logic [10:0] immediate_operand;
  logic        vlsu_en_o, vlsu_load_o, vlsu_store_o, vlsu_ready_i, busy;
`ifdef VSEQ_PERF_COUNT_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_issue_sequencer #(
    .NUM_LANES  (4),
    .VL_WIDTH   (5),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .apu_req          (apu_req),
    .apu_gnt          (apu_gnt),
    .apu_operands     (apu_operands),
    .apu_rvalid       (apu_rvalid),
    .vl               (vl),
    .vs1_addr         (vs1_addr),
    .vs2_addr         (vs2_addr),
    .vd_addr          (vd_addr),
    .lane_en          (lane_en),
    .beat_last        (beat_last),
    .vec_reg_write    (vec_reg_write),
    .csr_write        (csr_write),
    .scalar_operand   (scalar_operand),
    .immediate_operand(immediate_operand),
    .vlsu_en_o        (vlsu_en_o),
    .vlsu_load_o      (vlsu_load_o),
    .vlsu_store_o     (vlsu_store_o),
    .vlsu_ready_i     (vlsu_ready_i),
    .busy             (busy)
`ifdef VSEQ_PERF_COUNT_EN
    ,
    .perf_retired     (perf_retired),
    .perf_stall       (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk_opv(input logic [5:0] f6, input logic [4:0] vs2,
                                         input logic [4:0] vs1, input logic [2:0] f3,
                                         input logic [4:0] vd);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset      = 1'b0;
    apu_req      = 1'b0;
    apu_operands = '0;
    vl           = '0;
    vlsu_ready_i = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_rvalid", apu_rvalid, 0);
    check("rst_lane_en", lane_en, 0);
    check("rst_vd", vd_addr, 0);
    check("rst_vlsu_en", vlsu_en_o, 0);
    check("rst_wr", vec_reg_write, 0);
    check("rst_scalar", scalar_operand, 0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check("idle_gnt", apu_gnt, 1);

    // 1: vadd.vv vl=10 -> 3 beats
    vl = 5'd10;
    apu_operands[0] = mk_opv(6'b000000, 5'd12, 5'd8, 3'b000, 5'd4);
    apu_operands[1] = 32'hCAFE_0001;
    apu_req = 1'b1;
    #1 check("t1_gnt", apu_gnt, 1);
    step();
    apu_req = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_idle_lane", lane_en, 0);
    check("t1_scalar", scalar_operand, 32'hCAFE_0001);
    check("t1_imm", immediate_operand, 11'd8);
    step();
    check("t1_b0_lane", lane_en, 4'b1111);
    check("t1_b0_vd", vd_addr, 5'd4);
    check("t1_b0_vs1", vs1_addr, 5'd8);
    check("t1_b0_vs2", vs2_addr, 5'd12);
    check("t1_b0_wr", vec_reg_write, 1);
    check("t1_b0_last", beat_last, 0);
    step();
    check("t1_b1_lane", lane_en, 4'b1111);
    check("t1_b1_vd", vd_addr, 5'd5);
    check("t1_b1_vs1", vs1_addr, 5'd9);
    check("t1_b1_last", beat_last, 0);
    step();
    check("t1_b2_lane", lane_en, 4'b0011);
    check("t1_b2_vd", vd_addr, 5'd6);
    check("t1_b2_vs2", vs2_addr, 5'd14);
    check("t1_b2_last", beat_last, 1);
    check("t1_b2_wr", vec_reg_write, 1);
    check("t1_b2_rvalid", apu_rvalid, 0);
    step();
    check("t1_rvalid", apu_rvalid, 1);
    check("t1_ret_wr", vec_reg_write, 0);
    step();
    check("t1_rvalid_off", apu_rvalid, 0);
    check("t1_busy_off", busy, 0);

    // 2: vl=0 -> single empty beat
    vl = 5'd0;
    apu_operands[0] = mk_opv(6'b000000, 5'd2, 5'd3, 3'b000, 5'd1);
    apu_req = 1'b1;
    step();
    apu_req = 1'b0;
    step();
    check("t2_lane", lane_en, 0);
    check("t2_wr", vec_reg_write, 0);
    check("t2_last", beat_last, 1);
    check("t2_rvalid_early", apu_rvalid, 0);
    step();
    check("t2_rvalid", apu_rvalid, 1);
    step();
    check("t2_busy_off", busy, 0);

    // 5: vsetvli rs1=x0, rd=x3
    vl = 5'd7;
    apu_operands[0] = {1'b0, 11'h0D0, 5'd0, 3'b111, 5'd3, 7'b1010111};
    apu_req = 1'b1;
    step();
    apu_req = 1'b0;
    step();
    check("t5_csr", csr_write, 1);
    check("t5_wr", vec_reg_write, 0);
    check("t5_imm", immediate_operand, 11'h0D0);
    check("t5_last", beat_last, 1);
    step();
    check("t5_rvalid", apu_rvalid, 1);
    check("t5_csr_off", csr_write, 0);
    step();
    check("t5_busy_off", busy, 0);

    // 4: vle32.v vd=16, vl=6 (2 beats), first beat's ready delayed 5 cycles
    vl = 5'd6;
    apu_operands[0] = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b110, 5'd16, 7'b0000111};
    apu_req = 1'b1;
    step();
    apu_req = 1'b0;
    step();
    check("t4_exec_en", vlsu_en_o, 1);
    check("t4_exec_load", vlsu_load_o, 1);
    check("t4_exec_store", vlsu_store_o, 0);
    check("t4_exec_lane", lane_en, 4'b1111);
    check("t4_exec_wr", vec_reg_write, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_wait_en", vlsu_en_o, 1);
      check("t4_wait_vd", vd_addr, 5'd16);
      check("t4_wait_vs1", vs1_addr, 5'd10);
      check("t4_wait_wr", vec_reg_write, 0);
      step();
    end
    vlsu_ready_i = 1'b1;
    #1 check("t4_ready_wr", vec_reg_write, 1);
    check("t4_ready_vd", vd_addr, 5'd16);
    step();
    vlsu_ready_i = 1'b0;
    check("t4_b1_lane", lane_en, 4'b0011);
    check("t4_b1_vd", vd_addr, 5'd16);
    check("t4_b1_last", beat_last, 1);
    check("t4_b1_wr", vec_reg_write, 0);
    step();
    check("t4_b1_mem_en", vlsu_en_o, 1);
    vlsu_ready_i = 1'b1;
    #1 check("t4_b1_ready_wr", vec_reg_write, 1);
    step();
    vlsu_ready_i = 1'b0;
    check("t4_rvalid", apu_rvalid, 1);
    check("t4_ret_en", vlsu_en_o, 0);
    step();
    check("t4_busy_off", busy, 0);

    // 3: three back-to-back 1-beat requests into a 2-deep FIFO
    vl = 5'd4;
    apu_operands[0] = mk_opv(6'b000000, 5'd1, 5'd2, 3'b000, 5'd20);
    apu_req = 1'b1;
    #1 check("t3_gnt_a", apu_gnt, 1);
    step();
    apu_operands[0] = mk_opv(6'b000000, 5'd1, 5'd2, 3'b000, 5'd21);
    #1 check("t3_gnt_b", apu_gnt, 1);
    step();
    apu_operands[0] = mk_opv(6'b000000, 5'd1, 5'd2, 3'b000, 5'd22);
    #1 check("t3_gnt_c_full", apu_gnt, 0);
    check("t3_vd_a", vd_addr, 5'd20);
    step();
    check("t3_rvalid_a", apu_rvalid, 1);
    check("t3_gnt_ret", apu_gnt, 0);
    step();
    check("t3_gnt_after", apu_gnt, 1);
    check("t3_vd_b", vd_addr, 5'd21);
    step();
    apu_req = 1'b0;
    check("t3_rvalid_b", apu_rvalid, 1);
    step();
    check("t3_vd_c", vd_addr, 5'd22);
    check("t3_rvalid_gap", apu_rvalid, 0);
    step();
    check("t3_rvalid_c", apu_rvalid, 1);
    step();
    check("t3_busy_off", busy, 0);

    // 6: reset during beat 2 of 3 with a second instruction queued
    vl = 5'd10;
    apu_operands[0] = mk_opv(6'b000000, 5'd12, 5'd8, 3'b000, 5'd4);
    apu_req = 1'b1;
    step();
    apu_operands[0] = mk_opv(6'b000000, 5'd12, 5'd8, 3'b000, 5'd8);
    step();
    apu_req = 1'b0;
    step();
    check("t6_b1_vd", vd_addr, 5'd5);
    n_reset = 1'b0;
    #1 check("t6_rst_lane", lane_en, 0);
    check("t6_rst_wr", vec_reg_write, 0);
    check("t6_rst_vd", vd_addr, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rvalid", apu_rvalid, 0);
    check("t6_rst_scalar", scalar_operand, 0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check("t6_post_busy", busy, 0);
    check("t6_post_rvalid", apu_rvalid, 0);
    step();
    check("t6_post2_busy", busy, 0);
    check("t6_post2_rvalid", apu_rvalid, 0);
    check("t6_post2_lane", lane_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
